uart_tx_fifo_drain: RTL and testbench

- Serial UART transmitter that sits directly downstream of the team's FIFO read port.
- Pops one byte at a time from the FIFO and shifts it out as an 8N1 frame (LSB first) on a single TX line.
- Single clock domain: the FIFO read clock is tied to this block's i_clk.
- Frame pacing comes from an internal baud divider, so the FIFO absorbs producer bursts while this block drains at line rate.

---
 rtl/uart_tx_fifo_drain_pkg.sv | 30 +++
 rtl/uart_tx_fifo_drain_if.sv | 25 ++
 rtl/uart_tx_fifo_drain_baud_gen.sv | 38 +++
 rtl/uart_tx_fifo_drain.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types and sizing helpers for the FIFO-draining UART transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // Clocks per bit cell; integer division, so the residue is simply dropped.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that runs 0..clks_per_bit-1.
    function automatic int cnt_w_of(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    function automatic int calc_cnt_w(input int clk_hz, input int baud);
        return cnt_w_of(calc_clks_per_bit(clk_hz, baud));
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between a FIFO (slave) and the UART drain (master).
// Latency: read data valid the cycle after i/o_fifo_read.
// Backpressure: drain pops only when it is ready; FIFO signals emptiness via i_fifo_empty_n.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_LEN = 8
);
    logic                i_fifo_empty_n;
    logic [DATA_LEN-1:0] i_fifo_data;
    logic                i_fifo_read_error;
    logic                o_fifo_read;

    modport master (
        input  i_fifo_empty_n,
        input  i_fifo_data,
        input  i_fifo_read_error,
        output o_fifo_read
    );

    modport slave (
        output i_fifo_empty_n,
        output i_fifo_data,
        output i_fifo_read_error,
        input  o_fifo_read
    );
endinterface

// File: rtl/uart_tx_fifo_drain_baud_gen.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 and wraps, restartable via i_clear.
// Latency: o_tick high on the last clock of each bit cell; o_pre_tick one clock earlier.
// Backpressure: none; free-running except for i_clear.
// Ports: i_clk, i_reset_n (async, active-low), i_clear (restart at 0), o_tick, o_pre_tick.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int               CNT_W = cnt_w_of(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE   = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping exactly at LAST keeps every cell the same length, so no drift.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick     = (r_cnt == LAST);
    // Lets the parent register a pulse that lands on the last clock of a cell.
    assign o_pre_tick = (r_cnt == PRE);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter draining a FIFO read port; optional even parity via UART_TX_PARITY_EN.
// Latency: empty_n seen in IDLE at N -> pop at N+1, capture end of N+2, start bit at N+3.
// Backpressure: pops at most one byte per frame, only from IDLE with i_enable high.
// Ports: i_clk, i_reset_n (async, active-low), i_enable, fifo_if (master: empty_n/data/
//        read_error in, fifo_read out), o_tx (idle 1), o_busy, o_frame_done, o_underflow (sticky).
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int DATA_LEN     = 8,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    uart_tx_fifo_drain_if.master fifo_if,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_underflow
);

    localparam int               IDX_W    = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_LEN - 1);

    state_t              r_state, w_state_next;
    logic [DATA_LEN-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]    r_bit_idx, w_idx_next;
    logic                r_tx, r_busy, r_fifo_read, r_frame_done, r_underflow;
    logic                w_tx_next, w_busy_next, w_read_next, w_done_next;
    logic                w_clear, w_tick, w_pre_tick;
`ifdef UART_TX_PARITY_EN
    logic                r_parity, w_parity_next;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_clear),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // State register plus datapath and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_fifo_read  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_idx_next;
            r_tx         <= w_tx_next;
            r_busy       <= w_busy_next;
            r_fifo_read  <= w_read_next;
            r_frame_done <= w_done_next;
            r_underflow  <= r_underflow | fifo_if.i_fifo_read_error;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    // Next-state and datapath. empty_n is only looked at in IDLE, so a late
    // flag update from the FIFO after a pop cannot cause a second pop.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_idx_next    = r_bit_idx;
        w_clear       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (i_enable && fifo_if.i_fifo_empty_n) begin
                    w_state_next = POP;
                end
            end
            POP: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_shift_next  = fifo_if.i_fifo_data;
                w_clear       = 1'b1;
                w_state_next  = START;
`ifdef UART_TX_PARITY_EN
                w_parity_next = ^fifo_if.i_fifo_data;
`endif
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so that
    // every output can come straight from a flop.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != IDLE);
        w_read_next = (w_state_next == POP);
        // Pre-tick in STOP means the following clock is the last of the stop bit.
        w_done_next = (r_state == STOP) && w_pre_tick;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    assign o_tx                = r_tx;
    assign o_busy              = r_busy;
    assign o_frame_done        = r_frame_done;
    assign o_underflow         = r_underflow;
    assign fifo_if.o_fifo_read = r_fifo_read;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomised and directed bench for uart_tx_fifo_drain with a queue-based FIFO
// model and a frame scoreboard; a monitor checks every line clock of each frame.
module tb_uart_tx_fifo_drain;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 250000;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic tx, busy, done, underflow;

    uart_tx_fifo_drain_if #(.DATA_LEN(8)) fif ();

    uart_tx_fifo_drain #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DATA_LEN (8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_enable     (enable),
        .fifo_if      (fif),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_underflow  (underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a frame is start(0), data LSB first, [even parity], stop(1).
    function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
        logic [FB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    logic [7:0]    fifo_q[$];
    logic [FB-1:0] exp_q[$];
    int n_reads  = 0;
    int n_pushes = 0;

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(frame_of(b));
        n_pushes++;
    endtask

    // One clock: at the falling edge, serve a pop and refresh the FIFO flags.
    task automatic step();
        @(negedge clk);
        if (fif.o_fifo_read === 1'b1) begin
            n_reads++;
            chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) fif.i_fifo_data = fifo_q.pop_front();
        end
        fif.i_fifo_empty_n = (fifo_q.size() != 0);
    endtask

    // Monitor / scoreboard.
    bit            in_frame = 1'b0;
    int            pos = 0;
    logic [FB-1:0] cur = '1;
    int            last_end = -100;
    int            last_gap = -1;
    int            fall_cyc = -1;
    int            done_cyc = -1;
    int            n_frames = 0;
    logic          last_parity = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            pos      = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                fall_cyc = cyc;
                last_gap = cyc - last_end - 1;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                in_frame = 1'b1;
                pos      = 0;
            end
            if (in_frame) begin
                chk($sformatf("tx_bit%0d", pos / CPB), 32'(tx), 32'(cur[pos / CPB]));
                chk("busy_in_frame", 32'(busy), 32'd1);
                chk("frame_done_pos", 32'(done), 32'(pos == FLEN - 1));
                if (pos == 9 * CPB + 1) last_parity = tx;
                if (pos == FLEN - 1) begin
                    in_frame = 1'b0;
                    last_end = cyc;
                    done_cyc = cyc;
                    n_frames++;
                end
                pos++;
            end else begin
                chk("done_outside_frame", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        int n, r0, f0, rd_cyc, pushed;
        bit tx_stayed;

        fif.i_fifo_empty_n    = 1'b0;
        fif.i_fifo_data       = 8'h00;
        fif.i_fifo_read_error = 1'b0;

        // Reset defaults.
        repeat (4) step();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_read", 32'(fif.o_fifo_read), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) step();

        // Single byte latency.
        done_cyc = -1;
        rd_cyc   = -1;
        push(8'hA5);
        step();
        n  = cyc;
        r0 = n_reads;
        for (int k = 0; k < FLEN + 20; k++) begin
            step();
            if (fif.o_fifo_read === 1'b1 && rd_cyc < 0) rd_cyc = cyc;
            if (done_cyc >= 0) break;
        end
        chk("a5_read_cycle", 32'(rd_cyc - n), 32'd1);
        chk("a5_read_count", 32'(n_reads - r0), 32'd1);
        chk("a5_tx_fall", 32'(fall_cyc - n), 32'd3);
        chk("a5_frame_done", 32'(done_cyc - n), 32'(3 + FLEN - 1));

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07.
        done_cyc = -1;
        push(8'h07);
        for (int k = 0; k < FLEN + 20 && done_cyc < 0; k++) step();
        chk("p07_parity", 32'(last_parity), 32'd1);
        chk("p07_frame_len", 32'(done_cyc - fall_cyc + 1), 32'd44);
`endif

        // Back to back 0x00 then 0xFF.
        repeat (3) step();
        f0 = n_frames;
        r0 = n_reads;
        push(8'h00);
        push(8'hFF);
        for (int k = 0; k < 3 * FLEN && n_frames < f0 + 2; k++) step();
        chk("b2b_frames", 32'(n_frames - f0), 32'd2);
        chk("b2b_reads", 32'(n_reads - r0), 32'd2);
        chk("b2b_gap", 32'(last_gap), 32'd3);

        // Enable low blocks new frames.
        repeat (3) step();
        enable = 1'b0;
        r0 = n_reads;
        f0 = n_frames;
        tx_stayed = 1'b1;
        push(8'h3C);
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx !== 1'b1) tx_stayed = 1'b0;
        end
        chk("dis_no_read", 32'(n_reads - r0), 32'd0);
        chk("dis_tx_high", 32'(tx_stayed), 32'd1);
        chk("dis_not_busy", 32'(busy), 32'd0);
        // Release, then drop enable mid-frame; the scoreboard checks the frame.
        enable = 1'b1;
        for (int k = 0; k < 20 && tx !== 1'b0; k++) step();
        repeat (10) step();
        enable = 1'b0;
        for (int k = 0; k < FLEN + 10 && n_frames == f0; k++) step();
        chk("dis_mid_frame_done", 32'(n_frames - f0), 32'd1);
        enable = 1'b1;

        // Underflow is sticky.
        fif.i_fifo_read_error = 1'b1;
        step();
        fif.i_fifo_read_error = 1'b0;
        chk("underflow_set", 32'(underflow), 32'd1);
        repeat (10) step();
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Random traffic with enable toggling.
        pushed = 0;
        for (int t = 0; t < 2000 && pushed < 30; t++) begin
            step();
            if ($urandom_range(0, 15) == 0) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            if ($urandom_range(0, 40) == 0) enable = ~enable;
        end
        enable = 1'b1;
        for (int t = 0; t < 32 * (FLEN + 4) + 100 && (exp_q.size() != 0 || busy); t++) step();
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Reset during data bit 3 of 0x55.
        repeat (3) step();
        push(8'h55);
        for (int k = 0; k < 20 && tx !== 1'b0; k++) step();
        repeat (4 * CPB) step();
        chk("rst_bit3_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_high", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underflow_clr", 32'(underflow), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        r0 = n_reads;
        tx_stayed = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (tx !== 1'b1) tx_stayed = 1'b0;
        end
        chk("rst_no_repop", 32'(n_reads - r0), 32'd0);
        chk("rst_tx_idle", 32'(tx_stayed), 32'd1);

        chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
        chk("reads_match_pushes", 32'(n_reads), 32'(n_pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
